// File: rtl/da_pkg.sv
// Shared types and defaults for the DA LUT builder.
// Gray-code helper used by the step encoder and the builder.
package da_pkg;

  localparam int NTAPS = 4;
  localparam int CW    = 16;
  localparam int OW    = CW + $clog2(NTAPS);

  typedef enum logic [1:0] {
    COLLECT,
    BUILD,
    DONE
  } da_lut_state_t;

  function automatic int unsigned gray(input int unsigned j);
    return j ^ (j >> 1);
  endfunction

endpackage

// File: rtl/da_gray_step.sv
// Gray-walk step decoder: which coefficient flips at step j,
// and whether it enters (add) or leaves (subtract) the sum.
module da_gray_step #(
  parameter int NTAPS = da_pkg::NTAPS
) (
  input  logic [NTAPS-1:0]         j,
  output logic [$clog2(NTAPS)-1:0] b,
  output logic                     add
);
  import da_pkg::*;

  localparam int BW = $clog2(NTAPS);

  logic [NTAPS-1:0] gj;

  // trailing-zero priority encoder plus gray bit lookup
  always_comb begin
    b = '0;
    for (int i = NTAPS - 1; i >= 0; i--) begin
      if (j[i]) b = BW'(i);
    end
    gj  = NTAPS'(gray(32'(j)));
    add = gj[b];
  end

endmodule

// File: rtl/da_lut_builder.sv
// Collects NTAPS coefficients, then streams all 2^NTAPS
// DA partial sums in Gray order using a single adder.
module da_lut_builder #(
  parameter int NTAPS = da_pkg::NTAPS,
  parameter int CW    = da_pkg::CW,
  parameter int OW    = CW + $clog2(NTAPS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CW-1:0]    coef_in,
  input  logic             coef_valid,
  output logic             coef_ready,
  output logic [NTAPS-1:0] lut_addr,
  output logic [OW-1:0]    lut_data,
  output logic             lut_valid,
  output logic             cload,
  output logic             done
);
  import da_pkg::*;

  localparam int BW = $clog2(NTAPS);
  localparam int XW = OW - CW;
  localparam logic [NTAPS-1:0] J_LAST   = '1;
  localparam logic [BW-1:0]    IDX_LAST = BW'(NTAPS - 1);

  da_lut_state_t state;
  da_lut_state_t state_next;

  logic [CW-1:0]    coef [NTAPS];
  logic [BW-1:0]    idx;
  logic [NTAPS-1:0] j;
  logic [NTAPS-1:0] j_next;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    acc_next;
  logic [OW-1:0]    step_val;
  logic [BW-1:0]    flip;
  logic             add;
  logic             accept;
  logic             last_accept;

  assign accept      = (state == COLLECT) && coef_valid;
  assign last_accept = accept && (idx == IDX_LAST);
  assign j_next      = j + NTAPS'(1);

  da_gray_step #(
    .NTAPS(NTAPS)
  ) u_step (
    .j   (j_next),
    .b   (flip),
    .add (add)
  );

  assign step_val = {{XW{coef[flip][CW-1]}}, coef[flip]};
  assign acc_next = add ? (acc + step_val) : (acc - step_val);

  assign coef_ready = (state == COLLECT);
  assign cload      = lut_valid;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= COLLECT;
    else         state <= state_next;
  end

  // next-state logic; DONE is terminal until reset
  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT: if (last_accept)  state_next = BUILD;
      BUILD:   if (j == J_LAST)  state_next = DONE;
      DONE:                      state_next = DONE;
      default:                   state_next = COLLECT;
    endcase
  end

  // coefficient register file, written in arrival order
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (accept) begin
      coef[idx] <= coef_in;
    end
  end

  // counters, accumulator and registered ROM write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx       <= '0;
      j         <= '0;
      acc       <= '0;
      lut_addr  <= '0;
      lut_data  <= '0;
      lut_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (last_accept) begin
            idx       <= '0;
            j         <= '0;
            acc       <= '0;
            lut_addr  <= '0;
            lut_data  <= '0;
            lut_valid <= 1'b1;
          end else if (accept) begin
            idx <= idx + BW'(1);
          end
        end
        BUILD: begin
          if (j == J_LAST) begin
            lut_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            j        <= j_next;
            acc      <= acc_next;
            lut_addr <= NTAPS'(gray(32'(j_next)));
            lut_data <= acc_next;
          end
        end
        default: begin
          lut_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da_lut_builder.sv
// Directed bench for da_lut_builder: coefficient intake,
// Gray-ordered LUT stream, done timing and async reset.
module tb_da_lut_builder;

  logic        clk;
  logic        resetn;
  logic [15:0] coef_in;
  logic        coef_valid;
  logic        coef_ready;
  logic [3:0]  lut_addr;
  logic [17:0] lut_data;
  logic        lut_valid;
  logic        cload;
  logic        done;

  int checks;
  int errors;
  int cf  [4];
  int lut [16];
  int order [16] = '{0, 1, 3, 2, 6, 7, 5, 4,
                     12, 13, 15, 14, 10, 11, 9, 8};

  da_lut_builder dut (
    .clk        (clk),
    .resetn     (resetn),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .lut_valid  (lut_valid),
    .cload      (cload),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int a);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (((a >> i) & 1) == 1) s += cf[i];
    end
    return s;
  endfunction

  task automatic do_reset();
    resetn     = 1'b0;
    coef_valid = 1'b0;
    coef_in    = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) lut[i] = 99999;
  endtask

  task automatic stream(input bit gap, input bit extra);
    for (int i = 0; i < 4; i++) begin
      coef_in    = 16'(cf[i]);
      coef_valid = 1'b1;
      checks++;
      if (coef_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_collect beat %0d got %b want 1", i, coef_ready);
      end
      @(posedge clk);
      #1;
      if (gap && i < 3) begin
        coef_valid = 1'b0;
        coef_in    = 16'h0;
        @(posedge clk);
        #1;
      end
    end
    if (extra) begin
      coef_valid = 1'b1;
      coef_in    = 16'h7FFF;
    end else begin
      coef_valid = 1'b0;
      coef_in    = 16'h0;
    end
  endtask

  task automatic capture(input int stop_at);
    int v;
    for (int k = 0; k < 16; k++) begin
      if (k == stop_at) return;
      v = $signed(lut_data);
      checks++;
      if (lut_valid !== 1'b1 || cload !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL beat_flags k=%0d got valid=%b cload=%b done=%b want 1 1 0",
                 k, lut_valid, cload, done);
      end
      checks++;
      if (coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_build k=%0d got %b want 0", k, coef_ready);
      end
      checks++;
      if (int'(lut_addr) != order[k]) begin
        errors++;
        $display("FAIL addr_order k=%0d got %0d want %0d", k, lut_addr, order[k]);
      end
      checks++;
      if (v != model(int'(lut_addr))) begin
        errors++;
        $display("FAIL lut_data addr=%0d got %0d want %0d",
                 lut_addr, v, model(int'(lut_addr)));
      end
      lut[lut_addr] = v;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b1 || lut_valid !== 1'b0 || cload !== 1'b0) begin
      errors++;
      $display("FAIL done_latency got done=%b valid=%b cload=%b want 1 0 0",
               done, lut_valid, cload);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (coef_ready !== 1'b1 || lut_valid !== 1'b0 || cload !== 1'b0 ||
        done !== 1'b0 || lut_addr !== 4'd0 || lut_data !== 18'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b cl=%b d=%b a=%0d dat=%0d want 1 0 0 0 0 0",
               coef_ready, lut_valid, cload, done, lut_addr, lut_data);
    end
  endtask

  task automatic test_pow2();
    do_reset();
    cf = '{1, 2, 4, 8};
    stream(1'b0, 1'b0);
    capture(-1);
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (lut[a] != a) begin
        errors++;
        $display("FAIL pow2_entry addr=%0d got %0d want %0d", a, lut[a], a);
      end
    end
  endtask

  task automatic test_min();
    do_reset();
    cf = '{-32768, -32768, -32768, -32768};
    stream(1'b0, 1'b0);
    capture(-1);
    checks++;
    if (lut[15] != -131072) begin
      errors++;
      $display("FAIL min_addr15 got %0d want -131072", lut[15]);
    end
    checks++;
    if (lut[5] != -65536) begin
      errors++;
      $display("FAIL min_addr5 got %0d want -65536", lut[5]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    cf = '{3, -5, 7, 0};
    stream(1'b1, 1'b0);
    capture(-1);
    checks++;
    if (lut[3] != -2 || lut[6] != 2 || lut[7] != 5) begin
      errors++;
      $display("FAIL gaps_entries got a3=%0d a6=%0d a7=%0d want -2 2 5",
               lut[3], lut[6], lut[7]);
    end
  endtask

  task automatic test_extra_beat();
    do_reset();
    cf = '{100, -200, 300, -400};
    stream(1'b0, 1'b1);
    capture(-1);
    coef_valid = 1'b0;
    coef_in    = 16'h0;
    checks++;
    if (lut[15] != -200 || lut[1] != 100 || lut[12] != -100) begin
      errors++;
      $display("FAIL extra_entries got a15=%0d a1=%0d a12=%0d want -200 100 -100",
               lut[15], lut[1], lut[12]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cf = '{5, 6, 7, 8};
    stream(1'b0, 1'b0);
    capture(6);
    resetn = 1'b0;
    #1;
    checks++;
    if (lut_valid !== 1'b0 || cload !== 1'b0 || done !== 1'b0 ||
        lut_addr !== 4'd0 || lut_data !== 18'd0 || coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%b cl=%b d=%b a=%0d dat=%0d rdy=%b want 0 0 0 0 0 1",
               lut_valid, cload, done, lut_addr, lut_data, coef_ready);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) lut[i] = 99999;
    cf = '{1, 1, 1, 1};
    stream(1'b0, 1'b0);
    capture(-1);
    checks++;
    if (lut[15] != 4) begin
      errors++;
      $display("FAIL rebuild_addr15 got %0d want 4", lut[15]);
    end
  endtask

  task automatic test_idle_after_done();
    for (int i = 0; i < 50; i++) begin
      coef_valid = (i % 2 == 1);
      coef_in    = 16'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || lut_valid !== 1'b0 || cload !== 1'b0 ||
          coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_done cyc=%0d got d=%b v=%b cl=%b rdy=%b want 1 0 0 0",
                 i, done, lut_valid, cload, coef_ready);
      end
    end
    coef_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    coef_valid = 1'b0;
    coef_in    = '0;
    test_reset();
    test_pow2();
    test_min();
    test_gaps();
    test_extra_beat();
    test_mid_reset();
    test_idle_after_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_lut_builder.md
# da_lut_builder

Upstream feeder for the distributed-arithmetic FIR datapath. It accepts NTAPS raw signed filter coefficients over a valid/ready handshake, computes all 2^NTAPS DA partial-sum LUT entries with a single adder, and streams them into the DA ROM write port (`cload`/`lut_valid`). It raises `done` when the ROM is fully populated, so the DA controller's `start` may be gated on it. Coefficients change only through `resetn`; after `done` the block is idle until the next reset.

## Interface
- `NTAPS`, 4: number of taps, equal to the LUT address width.
- `CW`, 16: coefficient width, signed two's complement.
- `OW`, CW+$clog2(NTAPS) = 18: LUT entry width, signed.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `coef_in`  in  CW  coefficient; coefficient 0 arrives first.
- `coef_valid`  in  1  `coef_in` is valid.
- `coef_ready`  out  1  block can accept a coefficient.
- `lut_addr`  out  NTAPS  ROM write address.
- `lut_data`  out  OW  ROM write data, the sum of `coef[i]` over the bits i set in `lut_addr`.
- `lut_valid`  out  1  `lut_addr`/`lut_data` are valid this cycle.
- `cload`  out  1  ROM load-mode strobe, identical to `lut_valid`.
- `done`  out  1  all 2^NTAPS entries written; sticky until reset.

## Operation
- Three states: COLLECT, BUILD, DONE. Reset enters COLLECT.
- COLLECT
  - `coef_ready`=1.
  - A beat is accepted when `coef_valid & coef_ready`. It is stored in `coef[idx]` and `idx` increments.
  - Gaps in `coef_valid` are allowed, and beats are accepted back-to-back.
  - On the NTAPS-th accept, the next state is BUILD; `idx`, the step counter `j`, and the accumulator `acc` are cleared.
- BUILD: one entry per cycle in Gray-code order, so only one adder is needed.
  - Step j (0 .. 2^NTAPS−1) emits `lut_addr` = j ^ (j>>1).
  - Step 0 emits `lut_data` = 0.
  - For step j>0: let b = trailing-zero count of j. Then acc_next = acc + sext(`coef[b]`) if bit b of gray(j) is 1, otherwise acc − sext(`coef[b]`).
  - After step 2^NTAPS−1 the next state is DONE.
  - `coef_ready`=0; `coef_valid` is ignored.
- DONE: `done`=1, `coef_ready`=0, `lut_valid`=`cload`=0. This state is terminal.
- Arithmetic: every coefficient is sign-extended to OW before add or subtract. With OW = CW+$clog2(NTAPS), overflow cannot occur, so no saturation logic is needed.
- Reset at any time, including mid-BUILD, asynchronously forces COLLECT and zeroes every output. ROM contents from a partial build are don't-care; downstream must wait for `done`.

## Timing
- Reset values:
  - `coef_ready`=1 (COLLECT) once `resetn` deasserts.
  - `lut_valid`=`cload`=`done`=0.
  - `lut_addr`=0, `lut_data`=0.
- All outputs are registered.
- The cycle after the final coefficient accept, `lut_valid` rises. It stays high for exactly 2^NTAPS consecutive cycles, with no bubbles and no backpressure.
- `done` rises in the cycle after the last `lut_valid` and holds.
- Total latency from last accept to `done`: 2^NTAPS + 1 cycles (17 for defaults).
- `coef_ready` falls in the cycle after the NTAPS-th accept; a simultaneous extra `coef_valid` beat is not taken.

## Structure
- Shared package `da_pkg`:
  - `NTAPS`, `CW`, `OW` defaults.
  - State enum `da_lut_state_t` {COLLECT, BUILD, DONE}.
  - Function `gray(j)`.
- One sub-module, `da_gray_step`, which is combinational:
  - inputs j;
  - outputs flip bit index b and direction (add or subtract);
  - implemented as a trailing-zero priority encoder.
- Top-level contents: coefficient register file, `acc`, counters, FSM.

## Test plan
- Coefs {1,2,4,8} streamed back-to-back → 16 beats, `lut_data`==`lut_addr` on every beat; address order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; `done` 17 cycles after last accept.
- Coefs {−32768,−32768,−32768,−32768} → entry at addr 15 = −131072, entry at addr 5 = −65536, no wrap.
- Coefs {3,−5,7,0} with `coef_valid` toggling every other cycle → stored in order; addr 3 = −2, addr 6 = 2, addr 7 = 5.
- `coef_valid` held high through BUILD with value 0x7FFF → ignored; LUT contents match the case without the extra beat; `coef_ready`=0.
- `resetn` pulsed low at BUILD step 6 → all outputs 0 immediately (async); new coefs {1,1,1,1} → addr 15 = 4, `done` asserts normally.
- After `done`, 50 idle cycles with `coef_valid` toggling → `done` stays 1, `lut_valid`=0, no state change.
